// File: rtl/wm_sig_serializer.sv
// wm_sig_serializer: captures a signature and repeats it as preamble-framed, MSB-first serial frames.
module wm_sig_serializer #(
  parameter int WIDTH = 64,
  parameter int DIV = 16,
  parameter int PRE_W = 8,
  parameter logic [PRE_W-1:0] PREAMBLE = 8'hA5,
  parameter int GAP = 4,
  parameter int REPEAT = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_valid,
  input  logic [WIDTH-1:0] sig_value,
  output logic             ser_out,
  output logic             ser_en,
  output logic             busy,
  output logic             done,
  output logic             overrun
);
  localparam int FW = PRE_W + WIDTH;
  localparam int MAXC = (WIDTH > PRE_W) ? ((WIDTH > GAP) ? WIDTH : GAP) : ((PRE_W > GAP) ? PRE_W : GAP);
  localparam int CW = $clog2(MAXC + 1);
  localparam int TW = $clog2(DIV);
  localparam int RW = $clog2(REPEAT + 1);
  typedef enum logic [1:0] {S_IDLE, S_PRE, S_DATA, S_GAP} state_t;
  state_t state;
  logic [WIDTH-1:0] payload;
  logic [FW-1:0] sh;
  logic [TW-1:0] timer;
  logic [CW-1:0] cnt;
  logic [RW-1:0] rep;
  logic tick;
  assign tick = timer == TW'(DIV - 1);
  // outputs are loaded with the value of the bit about to start, so they change only on bit boundaries
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      payload <= '0;
      sh <= '0;
      timer <= '0;
      cnt <= '0;
      rep <= '0;
      ser_out <= 1'b0;
      ser_en <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      overrun <= 1'b0;
    end else begin
      done <= 1'b0;
      if (sig_valid && state != S_IDLE) overrun <= 1'b1;
      if (state == S_IDLE) begin
        if (sig_valid) begin
          payload <= sig_value;
          sh <= {PREAMBLE, sig_value};
          rep <= '0;
          timer <= '0;
          cnt <= '0;
          state <= S_PRE;
          ser_out <= PREAMBLE[PRE_W-1];
          ser_en <= 1'b1;
          busy <= 1'b1;
        end
      end else begin
        timer <= tick ? '0 : timer + 1'b1;
        if (tick) begin
          case (state)
            S_PRE: begin
              sh <= sh << 1;
              ser_out <= sh[FW-2];
              cnt <= (cnt == CW'(PRE_W - 1)) ? '0 : cnt + 1'b1;
              if (cnt == CW'(PRE_W - 1)) state <= S_DATA;
            end
            S_DATA: begin
              if (cnt == CW'(WIDTH - 1)) begin
                cnt <= '0;
                ser_out <= 1'b0;
                ser_en <= 1'b0;
                state <= S_GAP;
              end else begin
                cnt <= cnt + 1'b1;
                sh <= sh << 1;
                ser_out <= sh[FW-2];
              end
            end
            S_GAP: begin
              if (cnt == CW'(GAP - 1)) begin
                cnt <= '0;
                if (int'(rep) + 1 < REPEAT) begin
                  rep <= rep + 1'b1;
                  sh <= {PREAMBLE, payload};
                  ser_out <= PREAMBLE[PRE_W-1];
                  ser_en <= 1'b1;
                  state <= S_PRE;
                end else begin
                  busy <= 1'b0;
                  done <= 1'b1;
                  state <= S_IDLE;
                end
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
            default: state <= S_IDLE;
          endcase
        end
      end
    end
  end
endmodule

// File: tb/tb_wm_sig_serializer.sv
// tb_wm_sig_serializer: timing table plus serial-stream scoreboard for the signature serializer.
module tb_wm_sig_serializer;
  localparam int DIV = 4;
  localparam int GAP = 2;
  localparam int REPEAT = 2;
  localparam int WIDTH = 64;
  localparam int PRE_W = 8;
  localparam int TOTAL = REPEAT * (PRE_W + WIDTH + GAP) * DIV;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sig_valid = 1'b0;
  logic [WIDTH-1:0] sig_value = '0;
  logic ser_out, ser_en, busy, done, overrun;
  int nchk = 0;
  int nerr = 0;
  logic exp_q[$];
  typedef struct {
    int c;
    logic out;
    logic en;
    logic busy;
    logic done;
    bit co;
  } vec_t;
  vec_t vec[$];

  wm_sig_serializer #(.WIDTH(WIDTH), .DIV(DIV), .PRE_W(PRE_W), .PREAMBLE(8'hA5), .GAP(GAP), .REPEAT(REPEAT)) dut (
    .clk(clk), .rst(rst), .sig_valid(sig_valid), .sig_value(sig_value),
    .ser_out(ser_out), .ser_en(ser_en), .busy(busy), .done(done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic push_frames(input logic [WIDTH-1:0] v);
    logic [PRE_W-1:0] pre;
    pre = 8'hA5;
    for (int r = 0; r < REPEAT; r++) begin
      for (int b = PRE_W - 1; b >= 0; b--) for (int d = 0; d < DIV; d++) exp_q.push_back(pre[b]);
      for (int b = WIDTH - 1; b >= 0; b--) for (int d = 0; d < DIV; d++) exp_q.push_back(v[b]);
    end
  endtask

  // every enabled cycle must match the next expected bit, which also checks that each bit is held DIV cycles
  always @(negedge clk) begin
    if (ser_en === 1'b1) begin
      if (exp_q.size() == 0) chk("unexpected_ser_en", 1, 0);
      else chk("ser_out_stream", ser_out, exp_q.pop_front());
    end
  end

  task automatic run(input logic [WIDTH-1:0] val, input int ov_at, input int b2b_at,
                     input logic [WIDTH-1:0] b2b_val, input int rst_at, input int last);
    int ti;
    logic exp_ov;
    ti = 0;
    for (int c = 0; c <= last; c++) begin
      sig_valid = (c == 0) || (c == ov_at) || (c == b2b_at);
      sig_value = (c == 0) ? val : (c == ov_at) ? 64'hFFFF_FFFF_FFFF_FFFF : (c == b2b_at) ? b2b_val : {$urandom, $urandom};
      rst = (c == rst_at);
      if (c == 0) push_frames(val);
      if (c == b2b_at) push_frames(b2b_val);
      if (rst_at >= 0 && c == rst_at + 1) exp_q.delete();
      exp_ov = (ov_at >= 0 && c > ov_at);
      @(negedge clk);
      if (rst_at < 0) begin
        while (ti < vec.size() && vec[ti].c == c) begin
          chk($sformatf("en_c%0d", c), ser_en, vec[ti].en);
          chk($sformatf("busy_c%0d", c), busy, vec[ti].busy);
          chk($sformatf("done_c%0d", c), done, vec[ti].done);
          chk($sformatf("overrun_c%0d", c), overrun, exp_ov);
          if (vec[ti].co) chk($sformatf("out_c%0d", c), ser_out, vec[ti].out);
          ti++;
        end
      end else if (c == rst_at + 1) begin
        chk("rst_mid_outputs", {ser_out, ser_en, busy, done, overrun}, 5'b0);
      end else if (c > rst_at + 1) begin
        chk("rst_mid_no_done", done, 1'b0);
      end
      if (b2b_at >= 0 && c == b2b_at + 1) chk("b2b_ser_en", ser_en, 1'b1);
      if (b2b_at >= 0 && c == b2b_at + TOTAL + 1) chk("b2b_done", {busy, done}, 2'b01);
      if (c == last) chk("overrun_final", overrun, exp_ov);
      @(posedge clk);
      #1;
    end
    sig_valid = 1'b0;
    rst = 1'b0;
    chk("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    vec.push_back('{0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
    vec.push_back('{1,   1'b1, 1'b1, 1'b1, 1'b0, 1'b1});
    vec.push_back('{4,   1'b1, 1'b1, 1'b1, 1'b0, 1'b1});
    vec.push_back('{5,   1'b0, 1'b1, 1'b1, 1'b0, 1'b1});
    vec.push_back('{8,   1'b0, 1'b1, 1'b1, 1'b0, 1'b1});
    vec.push_back('{100, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
    vec.push_back('{101, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
    vec.push_back('{288, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
    vec.push_back('{289, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1});
    vec.push_back('{296, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1});
    vec.push_back('{297, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1});
    vec.push_back('{584, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
    vec.push_back('{585, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1});
    vec.push_back('{592, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1});
    vec.push_back('{593, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1});
    // reset held with sig_valid asserted must not capture anything
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      rst = 1'b1;
      sig_valid = 1'b1;
      sig_value = 64'h4C41424F5F49445F;
      @(negedge clk);
      chk("reset_outputs", {ser_out, ser_en, busy, done, overrun}, 5'b0);
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    sig_valid = 1'b0;
    @(negedge clk);
    chk("no_capture_in_reset", {ser_out, ser_en, busy, done, overrun}, 5'b0);
    @(posedge clk);
    #1;
    run(64'h4C41424F5F49445F, -1, TOTAL + 1, 64'h0123456789ABCDEF, -1, 2 * TOTAL + 4);
    run(64'h4C41424F5F49445F, 100, -1, '0, -1, TOTAL + 3);
    run(64'hDEADBEEFCAFEF00D, -1, -1, '0, 150, 160);
    run(64'h0123456789ABCDEF, -1, -1, '0, -1, TOTAL + 3);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule

// File: doc/wm_sig_serializer.md
Name: wm_sig_serializer

Overview:
- Downstream stage of the watermark proof detector.
- Captures the 64-bit signature presented with the one-cycle sig_valid pulse.
- Transmits the signature on a single pin as a framed, MSB-first serial stream with a fixed preamble, repeated a fixed number of times, so an external probe can read the watermark.
- Sits between the detector and the device debug/GPIO pad.

Parameters:
- WIDTH, 64, signature width in bits.
- DIV, 16, clock cycles per serial bit; legal range >= 2.
- PRE_W, 8, preamble length in bits; legal range >= 1.
- PREAMBLE, 8'hA5, preamble pattern, sent MSB-first.
- GAP, 4, idle bit-times after each frame; legal range >= 1.
- REPEAT, 3, frames sent per capture; legal range >= 1.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- sig_valid  in  1  one-cycle pulse: sig_value is valid
- sig_value  in  WIDTH  signature to transmit
- ser_out  out  1  serial data
- ser_en  out  1  high while a preamble or payload bit is driven
- busy  out  1  high from the cycle after capture until the transmission completes
- done  out  1  one-cycle pulse when all REPEAT frames have been sent
- overrun  out  1  sticky flag: sig_valid arrived while busy

Behaviour:
- All state is updated on the rising edge of clk.
- Reset: rst=1 at an edge forces state IDLE; ser_out, ser_en, busy, done and overrun =0; shift register, bit timer, bit counter and repeat counter =0.
- Reset mid-transmission aborts immediately, with no done pulse.
- FSM states: IDLE, PRE, DATA, GAP.
- IDLE:
  - ser_out=0, ser_en=0, busy=0.
  - sig_valid=1 latches sig_value into the payload register, clears the repeat counter and goes to PRE.
  - The first preamble bit appears on the very next cycle (latency 1).
- Bit timing:
  - The bit timer counts 0..DIV-1; each bit is held exactly DIV cycles.
  - A state/bit advance happens only on the cycle where timer==DIV-1; the timer then wraps to 0.
- PRE: drives PREAMBLE[PRE_W-1] down to [0], ser_en=1. After PRE_W bits, goes to DATA.
- DATA: drives payload[WIDTH-1] down to [0], ser_en=1. After WIDTH bits, goes to GAP.
- GAP: ser_out=0, ser_en=0, for GAP bit-times. Then:
  - if repeat count+1 < REPEAT: increment the count and go to PRE, resending the same latched payload;
  - otherwise go to IDLE.
- busy=1 in PRE, DATA and GAP.
- done=1 only on the first IDLE cycle after the last GAP.
- Total busy time = REPEAT*(PRE_W+WIDTH+GAP)*DIV cycles.
- Outputs are registered; ser_out/ser_en change only on bit boundaries.
- sig_valid while busy:
  - ignored; the payload is not modified;
  - overrun set to 1 and held until rst.
- sig_valid on the done cycle (state IDLE): accepted normally. No overrun; PRE starts on the next cycle.
- sig_value is sampled only in the capture cycle; later changes have no effect.
- Counter widths must hold PRE_W, WIDTH, GAP, REPEAT and DIV-1 with no wrap-around.

Test Plan:
- Bench configuration: DIV=4, WIDTH=64, PRE_W=8, PREAMBLE=8'hA5, GAP=2, REPEAT=2.
- Single capture:
  - Stimulus: sig_valid pulse at cycle 0 with sig_value=64'h4C41424F5F49445F.
  - Response: ser_en=1 on cycles 1..288 and 297..584. Sampling every 4 cycles yields A5 then 4C41424F5F49445F, twice. ser_out=0 during the gaps. busy=1 on cycles 1..592; done=1 only at cycle 593.
- Bit hold:
  - Stimulus: single capture as above.
  - Response: ser_out is constant within each 4-cycle window; the first 4 cycles are 1 (A5 MSB), the next 4 are 0.
- Overrun:
  - Stimulus: second sig_valid at cycle 100 with value 64'hFFFF_FFFF_FFFF_FFFF.
  - Response: the payload stream is unchanged, overrun=1 from cycle 101 until reset, and done still occurs at cycle 593.
- Back-to-back:
  - Stimulus: sig_valid on the done cycle (593) with 64'h0123456789ABCDEF.
  - Response: ser_en=1 at cycle 594 and the new payload is sent. overrun stays 0.
- Reset mid-op:
  - Stimulus: rst=1 at cycle 150 during DATA.
  - Response: next cycle all outputs are 0, no done pulse, and a new sig_valid restarts the frame cleanly.
- Reset values:
  - Stimulus: rst held for 3 cycles with sig_valid=1.
  - Response: no capture; all outputs remain 0 throughout.
